// File: rtl/factor_search_pkg.sv
// factor_search_pkg: shared state encoding and default factor width for factor_search
package factor_search_pkg;
   localparam int DEF_W = 4;
   typedef enum logic [1:0] {IDLE, MUL, CMP, DONE} state_t;
endpackage

// File: rtl/factor_mul_seq.sv
// factor_mul_seq: shift-add multiplier, one b bit per cycle LSB first, W cycles after start
module factor_mul_seq
   import factor_search_pkg::*;
#(
   parameter int W = DEF_W
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           start,
   input  logic [W-1:0]   a,
   input  logic [W-1:0]   b,
   output logic           done,
   output logic [2*W-1:0] prod
);
   localparam int CW = $clog2(W + 1);
   logic           run_q, run_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [2*W-1:0] a_q, a_d, acc_q, acc_d;
   logic [W-1:0]   b_q, b_d;
   assign done = run_q && (cnt_q == CW'(W - 1));
   assign prod = acc_q;
   // start loads operands; each running cycle adds the shifted multiplicand when the current b bit is set
   always_comb begin
      run_d = run_q;
      cnt_d = cnt_q;
      a_d   = a_q;
      b_d   = b_q;
      acc_d = acc_q;
      if (start) begin
         run_d = 1'b1;
         cnt_d = '0;
         a_d   = {{W{1'b0}}, a};
         b_d   = b;
         acc_d = '0;
      end else if (run_q) begin
         acc_d = acc_q + (b_q[0] ? a_q : '0);
         a_d   = a_q << 1;
         b_d   = b_q >> 1;
         cnt_d = cnt_q + CW'(1);
         run_d = !done;
      end
   end
   // state registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run_q <= 1'b0;
         cnt_q <= '0;
         a_q   <= '0;
         b_q   <= '0;
         acc_q <= '0;
      end else begin
         run_q <= run_d;
         cnt_q <= cnt_d;
         a_q   <= a_d;
         b_q   <= b_d;
         acc_q <= acc_d;
      end
   end
endmodule

// File: rtl/factor_search.sv
// factor_search: finds the factor pair of an operand with smallest f1 by ascending (f1, f2) enumeration
// Optional early exit once f1*f1 exceeds the operand: define FACTOR_SEARCH_PRUNE_EN
module factor_search
   import factor_search_pkg::*;
#(
   parameter int W = DEF_W
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [2*W-1:0] in_a,
   output logic           out_valid,
   input  logic           out_ready,
   output logic           out_found,
   output logic [W-1:0]   out_f1,
   output logic [W-1:0]   out_f2,
   output logic           busy
);
   localparam logic [W-1:0] FMAX = '1;
   state_t         state_q, state_d;
   logic [2*W-1:0] op_q, op_d;
   logic [W-1:0]   f1_q, f1_d, f2_q, f2_d, r1_q, r1_d, r2_q, r2_d;
   logic           found_q, found_d;
   logic           start, mul_done, prune;
   logic [2*W-1:0] prod;
   assign in_ready  = (state_q == IDLE);
   assign busy      = !in_ready;
   assign out_valid = (state_q == DONE);
   assign out_found = found_q;
   assign out_f1    = r1_q;
   assign out_f2    = r2_q;
   // the multiplier loads the candidate that the FSM is about to enter MUL with
   factor_mul_seq #(.W(W)) u_mul (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (f1_d),
      .b     (f2_d),
      .done  (mul_done),
      .prod  (prod)
   );
   // FSM: accept, multiply, compare, then step to the next candidate or report
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      f1_d    = f1_q;
      f2_d    = f2_q;
      r1_d    = r1_q;
      r2_d    = r2_q;
      found_d = found_q;
      start   = 1'b0;
      prune   = 1'b0;
`ifdef FACTOR_SEARCH_PRUNE_EN
      prune = (f1_q == f2_q) && (prod > op_q);
`else
      prune = 1'b0;
`endif
      case (state_q)
         IDLE: if (in_valid) begin
            op_d    = in_a;
            f1_d    = W'(2);
            f2_d    = W'(2);
            start   = 1'b1;
            state_d = MUL;
         end
         MUL: state_d = mul_done ? CMP : MUL;
         CMP: if (prod == op_q) begin
            found_d = 1'b1;
            r1_d    = f1_q;
            r2_d    = f2_q;
            state_d = DONE;
         end else if (prune || (f1_q == FMAX && f2_q == FMAX)) begin
            found_d = 1'b0;
            r1_d    = '0;
            r2_d    = '0;
            state_d = DONE;
         end else begin
            f1_d    = (f2_q == FMAX) ? f1_q + W'(1) : f1_q;
            f2_d    = (f2_q == FMAX) ? f1_q + W'(1) : f2_q + W'(1);
            start   = 1'b1;
            state_d = MUL;
         end
         DONE: state_d = out_ready ? IDLE : DONE;
         default: state_d = IDLE;
      endcase
   end
   // state registers; reset abandons any search in progress
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         op_q    <= '0;
         f1_q    <= '0;
         f2_q    <= '0;
         r1_q    <= '0;
         r2_q    <= '0;
         found_q <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         f1_q    <= f1_d;
         f2_q    <= f2_d;
         r1_q    <= r1_d;
         r2_q    <= r2_d;
         found_q <= found_d;
      end
   end
endmodule

// File: tb/tb_factor_search.sv
// tb_factor_search: directed vector table plus reset and busy-input sequences for factor_search
module tb_factor_search;
   import factor_search_pkg::*;
   typedef struct {
      logic [7:0] a;
      logic       found;
      logic [3:0] f1;
      logic [3:0] f2;
      int         lat;
      int         hold;
   } tv_t;
   logic       clk = 1'b0;
   logic       rst_n, in_valid, in_ready, out_valid, out_ready, out_found, busy;
   logic [7:0] in_a;
   logic [3:0] out_f1, out_f2;
   int checks = 0;
   int failures = 0;
   tv_t tv[12];
   always #5 clk = ~clk;
   factor_search #(.W(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_found (out_found),
      .out_f1    (out_f1),
      .out_f2    (out_f2),
      .busy      (busy)
   );
   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask
   task automatic wait_done(output int n);
      n = 0;
      while (!out_valid && n < 1000) begin
         @(posedge clk);
         #1;
         n++;
      end
   endtask
   task automatic handshake();
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk("valid_dropped", int'(out_valid), 0);
      chk("ready_back", int'(in_ready), 1);
   endtask
   task automatic run(input tv_t v);
      int  n;
      bit  stable;
      bit  lat_ok;
      chk("ready_idle", int'(in_ready), 1);
      in_a = v.a;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      chk("busy_after_accept", int'(busy), 1);
      wait_done(n);
      chk("valid_seen", int'(out_valid), 1);
      lat_ok = (n == v.lat);
`ifdef FACTOR_SEARCH_PRUNE_EN
      if (!v.found) lat_ok = (n <= v.lat);
`endif
      if (!lat_ok) $display("  operand %0h latency %0d vs %0d", v.a, n, v.lat);
      chk("latency_ok", int'(lat_ok), 1);
      chk("found", int'(out_found), int'(v.found));
      chk("f1", int'(out_f1), int'(v.f1));
      chk("f2", int'(out_f2), int'(v.f2));
      chk("ready_in_done", int'(in_ready), 0);
      if (v.hold > 0) begin
         stable = 1'b1;
         for (int i = 0; i < v.hold; i++) begin
            @(posedge clk);
            #1;
            if (!out_valid || out_found !== v.found || out_f1 !== v.f1 || out_f2 !== v.f2 || in_ready)
               stable = 1'b0;
         end
         chk("hold_stable", int'(stable), 1);
      end
      handshake();
   endtask
   initial begin
      int  n;
      bit  ok;
      tv[0]  = '{8'h04, 1'b1, 4'd2,  4'd2,  5,   0};
      tv[1]  = '{8'h06, 1'b1, 4'd2,  4'd3,  10,  0};
      tv[2]  = '{8'h0C, 1'b1, 4'd2,  4'd6,  25,  0};
      tv[3]  = '{8'h10, 1'b1, 4'd2,  4'd8,  35,  0};
      tv[4]  = '{8'h1E, 1'b1, 4'd2,  4'd15, 70,  0};
      tv[5]  = '{8'h51, 1'b1, 4'd9,  4'd9,  390, 0};
      tv[6]  = '{8'h8F, 1'b1, 4'd11, 4'd13, 465, 0};
      tv[7]  = '{8'hE1, 1'b1, 4'd15, 4'd15, 525, 0};
      tv[8]  = '{8'h0D, 1'b0, 4'd0,  4'd0,  525, 0};
      tv[9]  = '{8'h01, 1'b0, 4'd0,  4'd0,  525, 0};
      tv[10] = '{8'h00, 1'b0, 4'd0,  4'd0,  525, 20};
      tv[11] = '{8'hFF, 1'b0, 4'd0,  4'd0,  525, 20};
      rst_n = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b0;
      in_a = '0;
      #12;
      chk("rst_in_ready", int'(in_ready), 1);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_found", int'(out_found), 0);
      chk("rst_f1", int'(out_f1), 0);
      chk("rst_f2", int'(out_f2), 0);
      chk("rst_busy", int'(busy), 0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      for (int i = 0; i < 12; i++) run(tv[i]);
      // asynchronous reset in the middle of MUL
      in_a = 8'h8F;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chk("midrst_valid", int'(out_valid), 0);
      chk("midrst_busy", int'(busy), 0);
      chk("midrst_ready", int'(in_ready), 1);
      @(posedge clk);
      #3;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      run(tv[1]);
      // in_valid toggled with a different operand while busy
      in_a = 8'h06;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      ok = 1'b1;
      n = 0;
      while (!out_valid && n < 1000) begin
         in_valid = ~in_valid;
         in_a = 8'h04;
         @(posedge clk);
         #1;
         n++;
         if (!out_valid && (in_ready || !busy)) ok = 1'b0;
      end
      in_valid = 1'b0;
      chk("toggle_no_ready", int'(ok), 1);
      chk("toggle_latency", n, 10);
      chk("toggle_found", int'(out_found), 1);
      chk("toggle_f1", int'(out_f1), 2);
      chk("toggle_f2", int'(out_f2), 3);
      handshake();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
